// File: rtl/alu_pipe2.sv
// alu_pipe2: two-stage ALU with the carry chain split at SPLIT and valid/ready on both sides.
// Define ALU_SHIFT_EN to add SLL (Sel 100) and SRL (Sel 101), barrel-shifted in stage 2.
module alu_pipe2 #(
    parameter int WIDTH = 32,
    parameter int SPLIT = WIDTH / 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [2:0]       Sel,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    input  logic [TAG_W-1:0] TagIn,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] DataOut,
    output logic [TAG_W-1:0] TagOut,
    output logic             Zero,
    output logic             Overflow,
    output logic             CarryOut
);
    localparam int HI_W = WIDTH - SPLIT;
`ifdef ALU_SHIFT_EN
    localparam int SH_W = $clog2(WIDTH);
`endif

    logic                 s1_valid_q, s2_valid_q, s1_load, s2_load;
    logic [SPLIT-1:0]     lo_sum_q;
    logic                 lo_carry_q;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [WIDTH-1:SPLIT] bn_hi_q;
    logic [2:0]           sel_q;
    logic [TAG_W-1:0]     tag_q;
    logic [WIDTH-1:0]     data_q;
    logic [TAG_W-1:0]     tag_out_q;
    logic                 zero_q, ovf_q, carry_q;

    logic                 cin_d;
    logic [WIDTH-1:0]     bn_d;
    logic [SPLIT:0]       lo_d;
    logic [HI_W:0]        hi_d;
    logic [WIDTH-1:0]     sum_d, res_d;
    logic                 ovf_d, arith_d;

    assign s2_load = ~s2_valid_q | OutReady;
    assign s1_load = ~s1_valid_q | s2_load;
    assign InReady = s1_load;

    // SUB and SLT subtract as A + ~B + 1
    assign cin_d = (Sel == 3'b110) | (Sel == 3'b111);
    assign bn_d  = cin_d ? ~DataB : DataB;
    assign lo_d  = {1'b0, DataA[SPLIT-1:0]} + {1'b0, bn_d[SPLIT-1:0]} + {{SPLIT{1'b0}}, cin_d};

    assign hi_d    = {1'b0, a_q[WIDTH-1:SPLIT]} + {1'b0, bn_hi_q} + {{HI_W{1'b0}}, lo_carry_q};
    assign sum_d   = {hi_d[HI_W-1:0], lo_sum_q};
    assign ovf_d   = (a_q[WIDTH-1] == bn_hi_q[WIDTH-1]) & (sum_d[WIDTH-1] != a_q[WIDTH-1]);
    assign arith_d = (sel_q == 3'b010) | (sel_q == 3'b110);

    always_comb begin
        res_d = '0;
        case (sel_q)
            3'b000:         res_d = a_q & b_q;
            3'b001:         res_d = a_q | b_q;
            3'b011:         res_d = ~(a_q | b_q);
            3'b010, 3'b110: res_d = sum_d;
            3'b111:         res_d = {{(WIDTH-1){1'b0}}, sum_d[WIDTH-1] ^ ovf_d};
`ifdef ALU_SHIFT_EN
            3'b100:         res_d = a_q << b_q[SH_W-1:0];
            3'b101:         res_d = a_q >> b_q[SH_W-1:0];
`endif
            default:        res_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            lo_sum_q   <= '0;
            lo_carry_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            bn_hi_q    <= '0;
            sel_q      <= '0;
            tag_q      <= '0;
        end else if (s1_load) begin
            s1_valid_q <= InValid;
            if (InValid) begin
                lo_sum_q   <= lo_d[SPLIT-1:0];
                lo_carry_q <= lo_d[SPLIT];
                a_q        <= DataA;
                b_q        <= DataB;
                bn_hi_q    <= bn_d[WIDTH-1:SPLIT];
                sel_q      <= Sel;
                tag_q      <= TagIn;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            data_q     <= '0;
            tag_out_q  <= '0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            carry_q    <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                data_q    <= res_d;
                tag_out_q <= tag_q;
                zero_q    <= (res_d == '0);
                ovf_q     <= arith_d & ovf_d;
                carry_q   <= arith_d & hi_d[HI_W];
            end
        end
    end

    assign OutValid = s2_valid_q;
    assign DataOut  = data_q;
    assign TagOut   = tag_out_q;
    assign Zero     = zero_q;
    assign Overflow = ovf_q;
    assign CarryOut = carry_q;
endmodule

// File: tb/tb_alu_pipe2.sv
// tb_alu_pipe2: vector table, handshake corner sequences and a random scoreboard run for alu_pipe2.
module tb_alu_pipe2;
    logic        clk = 0, rst_n = 0, InValid = 0, InReady, OutValid, OutReady = 1;
    logic [2:0]  Sel = '0;
    logic [31:0] DataA = '0, DataB = '0, DataOut;
    logic [3:0]  TagIn = '0, TagOut;
    logic        Zero, Overflow, CarryOut;

    alu_pipe2 #(.WIDTH(32), .SPLIT(16), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady), .Sel(Sel),
        .DataA(DataA), .DataB(DataB), .TagIn(TagIn), .OutValid(OutValid), .OutReady(OutReady),
        .DataOut(DataOut), .TagOut(TagOut), .Zero(Zero), .Overflow(Overflow), .CarryOut(CarryOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] a, b;
        logic [3:0]  tag;
        logic [31:0] d;
        logic        z, o, c;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  t;
        logic        z, o, c;
    } exp_t;

    localparam longint MAXI = 64'sh7FFFFFFF;
    localparam longint MINI = -MAXI - 1;

    int   n_cmp = 0, n_bad = 0, rx = 0;
    exp_t q[$];
    vec_t vt[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] t);
        exp_t        e;
        longint      sa, sb, r;
        logic [32:0] w;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        e.d = '0; e.o = 0; e.c = 0; e.t = t;
        case (s)
            3'b000: e.d = a & b;
            3'b001: e.d = a | b;
            3'b011: e.d = ~(a | b);
            3'b010: begin
                w = {1'b0, a} + {1'b0, b};
                r = sa + sb;
                e.d = w[31:0]; e.c = w[32]; e.o = (r > MAXI) || (r < MINI);
            end
            3'b110: begin
                r = sa - sb;
                e.d = a - b; e.c = (a >= b); e.o = (r > MAXI) || (r < MINI);
            end
            3'b111: e.d = (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
            3'b100: e.d = a << b[4:0];
            3'b101: e.d = a >> b[4:0];
`endif
            default: e.d = '0;
        endcase
        e.z = (e.d == 0);
        return e;
    endfunction

    task automatic send(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t);
        int k = 0;
        InValid = 1; Sel = s; DataA = a; DataB = b; TagIn = t;
        @(negedge clk);
        while (!InReady && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) chk("in_ready_timeout", {31'b0, InReady}, 32'd1);
        @(posedge clk);
        #1 InValid = 0;
    endtask

    initial begin
        int   lat, n, cyc;
        bit   done;
        exp_t e;
        vt[0]  = '{3'b010, 32'h0000FFFF, 32'h00000001, 4'd3, 32'h00010000, 0, 0, 0};
        vt[1]  = '{3'b110, 32'h80000000, 32'h00000001, 4'd1, 32'h7FFFFFFF, 0, 1, 1};
        vt[2]  = '{3'b111, 32'hFFFFFFFF, 32'h00000001, 4'd2, 32'h00000001, 0, 0, 0};
        vt[3]  = '{3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 4'd4, 32'hF000F000, 0, 0, 0};
        vt[4]  = '{3'b001, 32'h00000000, 32'h00000000, 4'd5, 32'h00000000, 1, 0, 0};
        vt[5]  = '{3'b011, 32'h00000000, 32'h00000000, 4'd6, 32'hFFFFFFFF, 0, 0, 0};
        vt[6]  = '{3'b010, 32'hFFFFFFFF, 32'h00000001, 4'd7, 32'h00000000, 1, 0, 1};
        vt[7]  = '{3'b010, 32'h7FFFFFFF, 32'h00000001, 4'd8, 32'h80000000, 0, 1, 0};
        vt[8]  = '{3'b110, 32'h00000005, 32'h00000005, 4'd9, 32'h00000000, 1, 0, 1};
        vt[9]  = '{3'b111, 32'h00000001, 32'hFFFFFFFF, 4'd10, 32'h00000000, 1, 0, 0};
`ifdef ALU_SHIFT_EN
        vt[10] = '{3'b100, 32'h00000001, 32'd31, 4'd11, 32'h80000000, 0, 0, 0};
        vt[11] = '{3'b101, 32'h80000000, 32'd31, 4'd12, 32'h00000001, 0, 0, 0};
`else
        vt[10] = '{3'b100, 32'h00000001, 32'd31, 4'd11, 32'h00000000, 1, 0, 0};
        vt[11] = '{3'b101, 32'h80000000, 32'd31, 4'd12, 32'h00000000, 1, 0, 0};
`endif
        vt[12] = '{3'b110, 32'h00000000, 32'h00000001, 4'd13, 32'hFFFFFFFF, 0, 0, 0};
        vt[13] = '{3'b111, 32'h80000000, 32'h7FFFFFFF, 4'd14, 32'h00000001, 0, 0, 0};

        fork
            forever begin
                @(negedge clk);
                if (!rst_n) q.delete();
                else begin
                    if (OutValid && OutReady) begin
                        rx++;
                        if (q.size() == 0) chk("sb_unexpected_out", {31'b0, OutValid}, 32'd0);
                        else begin
                            e = q.pop_front();
                            chk("sb_data", DataOut, e.d);
                            chk("sb_tag", {28'b0, TagOut}, {28'b0, e.t});
                            chk("sb_flags", {29'b0, Zero, Overflow, CarryOut}, {29'b0, e.z, e.o, e.c});
                        end
                    end
                    if (InValid && InReady) q.push_back(model(Sel, DataA, DataB, TagIn));
                end
            end
        join_none

        repeat (2) @(negedge clk);
        chk("rst_outvalid", {31'b0, OutValid}, 32'd0);
        chk("rst_data", DataOut, 32'd0);
        chk("rst_tag", {28'b0, TagOut}, 32'd0);
        chk("rst_flags", {29'b0, Zero, Overflow, CarryOut}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_inready", {31'b0, InReady}, 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            send(vt[i].sel, vt[i].a, vt[i].b, vt[i].tag);
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!OutValid && lat < 20);
            chk("vec_latency", lat, 2);
            chk("vec_data", DataOut, vt[i].d);
            chk("vec_tag", {28'b0, TagOut}, {28'b0, vt[i].tag});
            chk("vec_flags", {29'b0, Zero, Overflow, CarryOut}, {29'b0, vt[i].z, vt[i].o, vt[i].c});
            @(posedge clk);
            #1;
        end

        fork
            for (int i = 0; i < 8; i++)
                send(3'($urandom_range(0, 7)), $urandom, $urandom, 4'(i));
        join_none
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!OutValid && n < 20);
        for (int j = 0; j < 8; j++) begin
            chk("b2b_valid", {31'b0, OutValid}, 32'd1);
            chk("b2b_tag", {28'b0, TagOut}, 32'(j));
            @(negedge clk);
        end
        @(posedge clk);
        #1;

        OutReady = 0;
        send(3'b010, 32'h00001234, 32'h00000011, 4'd9);
        send(3'b110, 32'h00000010, 32'h00000020, 4'd10);
        e = model(3'b010, 32'h00001234, 32'h00000011, 4'd9);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("stall_inready", {31'b0, InReady}, 32'd0);
            chk("stall_outvalid", {31'b0, OutValid}, 32'd1);
            chk("stall_data", DataOut, e.d);
            chk("stall_tag", {28'b0, TagOut}, 32'd9);
        end
        @(posedge clk);
        #1 OutReady = 1;
        n = rx;
        send(3'b001, 32'h0000F000, 32'h0000000F, 4'd11);
        repeat (6) @(negedge clk);
        chk("drain_count", rx - n, 3);
        chk("drain_empty", q.size(), 0);
        @(posedge clk);
        #1;

        done = 0;
        n = rx;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(3'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                         4'($urandom));
                end
                done = 1;
            end
        join_none
        cyc = 0;
        while (!(done && q.size() == 0) && cyc < 5000) begin
            @(posedge clk);
            #1 OutReady = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        OutReady = 1;
        chk("rand_done", {31'b0, done}, 32'd1);
        chk("rand_count", rx - n, 300);
        chk("rand_empty", q.size(), 0);
        @(posedge clk);
        #1;

        OutReady = 0;
        send(3'b010, 32'h11111111, 32'h22222222, 4'd5);
        send(3'b000, 32'hFFFFFFFF, 32'h0F0F0F0F, 4'd6);
        #2 rst_n = 0;
        #1;
        chk("midrst_outvalid", {31'b0, OutValid}, 32'd0);
        chk("midrst_data", DataOut, 32'd0);
        chk("midrst_tag", {28'b0, TagOut}, 32'd0);
        chk("midrst_flags", {29'b0, Zero, Overflow, CarryOut}, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1;
        OutReady = 1;
        @(negedge clk);
        chk("midrst_inready", {31'b0, InReady}, 32'd1);
        n = 0;
        repeat (5) begin
            @(negedge clk);
            n += int'(OutValid);
        end
        chk("midrst_no_stale", n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
